// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline control unit: stall encodings, exception codes, FSM states.
package pipe_ctrl_pkg;

    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;

    localparam logic [31:0] EXC_INT          = 32'h0000_0001;
    localparam logic [31:0] EXC_SYSCALL      = 32'h0000_0008;
    localparam logic [31:0] EXC_INST_INVALID = 32'h0000_000A;
    localparam logic [31:0] EXC_OV           = 32'h0000_000C;
    localparam logic [31:0] EXC_TRAP         = 32'h0000_000D;
    localparam logic [31:0] EXC_ERET         = 32'h0000_000E;

    localparam int unsigned REFILL_CNT_W = 4;
    localparam int unsigned WDOG_CNT_W   = 16;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_REFILL = 1'b1
    } state_e;

    // The deepest requesting stage freezes itself and everything upstream of it.
    function automatic logic [5:0] stall_encode(input logic id, input logic ex, input logic mem);
        if (mem) begin
            return STALL_MEM;
        end else if (ex) begin
            return STALL_EX;
        end else if (id) begin
            return STALL_ID;
        end
        return STALL_NONE;
    endfunction

endpackage

// File: rtl/pipe_ctrl_wdog.sv
// Stall watchdog: counts consecutive stalled cycles and fires a one-cycle flush request
// the cycle after the limit is reached.
module pipe_ctrl_wdog
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned WDOG_LIMIT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic stalled,
    input  logic flush,
    output logic fire
);

    localparam logic [WDOG_CNT_W-1:0] LIMIT_M1 = WDOG_CNT_W'(WDOG_LIMIT - 1);

    logic [WDOG_CNT_W-1:0] cnt_q, cnt_d;
    logic                  fire_q, fire_d;

    always_comb begin
        cnt_d  = '0;
        fire_d = 1'b0;
        if (stalled && !flush) begin
            cnt_d  = cnt_q + 1'b1;
            fire_d = (cnt_q == LIMIT_M1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            fire_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            fire_q <= fire_d;
        end
    end

    assign fire = fire_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: stall merge, exception flush / new_pc, post-flush refill FSM, flush counter.
// Optional stall watchdog is built when STALL_WDOG_EN is defined.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR    = 32'h0000_0020,
    parameter int unsigned REFILL_CYCLES = 4,
    parameter int unsigned WDOG_LIMIT    = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_from_id,
    input  logic        stallreq_from_ex,
    input  logic        stallreq_from_mem,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] cp0_epc_i,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        in_refill_o,
    output logic [15:0] exc_count_o,
    output logic        wdog_timeout_o
);

    localparam logic [REFILL_CNT_W-1:0] REFILL_RELOAD = REFILL_CNT_W'(REFILL_CYCLES - 1);

    state_e                  state_q, state_d;
    logic [REFILL_CNT_W-1:0] refill_cnt_q, refill_cnt_d;
    logic [15:0]             exc_count_q, exc_count_d;
    logic                    exc_valid;
    logic                    wdog_fire;
    logic                    flush_req;

    // Interrupts are held off until the refill window has drained.
    assign exc_valid = (excepttype_i != '0) &&
                       !((state_q == ST_REFILL) && (excepttype_i == EXC_INT));
    assign flush_req = exc_valid || wdog_fire;

`ifdef STALL_WDOG_EN
    pipe_ctrl_wdog #(
        .WDOG_LIMIT (WDOG_LIMIT)
    ) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .stalled (|stall),
        .flush   (flush),
        .fire    (wdog_fire)
    );
`else
    logic unused_wdog_limit;
    assign unused_wdog_limit = (WDOG_LIMIT == 0);
    assign wdog_fire         = 1'b0;
`endif

    always_comb begin
        stall  = STALL_NONE;
        flush  = 1'b0;
        new_pc = '0;
        if (!rst) begin
            if (flush_req) begin
                flush  = 1'b1;
                new_pc = (exc_valid && (excepttype_i == EXC_ERET)) ? cp0_epc_i : EXC_VECTOR;
            end else begin
                stall = stall_encode(stallreq_from_id, stallreq_from_ex, stallreq_from_mem);
            end
        end
    end

    assign in_refill_o    = !rst && (state_q == ST_REFILL);
    assign exc_count_o    = rst ? '0 : exc_count_q;
    assign wdog_timeout_o = !rst && wdog_fire && !exc_valid;

    always_comb begin
        state_d      = state_q;
        refill_cnt_d = refill_cnt_q;
        unique case (state_q)
            ST_RUN: begin
                if (flush_req) begin
                    state_d      = ST_REFILL;
                    refill_cnt_d = REFILL_RELOAD;
                end
            end
            ST_REFILL: begin
                if (flush_req) begin
                    refill_cnt_d = REFILL_RELOAD;
                end else if (refill_cnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    refill_cnt_d = refill_cnt_q - 1'b1;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    assign exc_count_d = (flush_req && (exc_count_q != 16'hFFFF)) ? exc_count_q + 16'd1
                                                                  : exc_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_RUN;
            refill_cnt_q <= '0;
            exc_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            refill_cnt_q <= refill_cnt_d;
            exc_count_q  <= exc_count_d;
        end
    end

endmodule
